// File: rtl/dvr_pkg.sv
// ============================================================================
// dvr_pkg : shared types and helpers for the DVR serializer block
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package dvr_pkg;

    typedef enum logic {IDLE, SEND} dvr_ser_state_t;

    // Chunks per wide word; a zero OUT_BYTES is caught by the module's parameter check.
    function automatic int dvr_chunk_count(input int in_bytes, input int out_bytes);
        return (out_bytes < 1) ? 1 : in_bytes / out_bytes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dvr_if.sv
// ============================================================================
// dvr_if : data / valid / rdy handshake bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface dvr_if #(
    parameter int DATA_WIDTH_IN_BYTES = 32
) ();

    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic                             valid;
    logic                             rdy;

    modport master (output data, output valid, input  rdy);
    modport slave  (input  data, input  valid, output rdy);

endinterface

`default_nettype wire

// File: rtl/dvr_serializer.sv
// ============================================================================
// dvr_serializer : splits wide DVR words into MSB-first narrow chunks
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dvr_serializer
    import dvr_pkg::*;
#(
    parameter int IN_BYTES  = 32,
    parameter int OUT_BYTES = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    dvr_if.slave  data_in,
    dvr_if.master data_out,
    output logic  last_chunk
);

    localparam int N     = dvr_chunk_count(IN_BYTES, OUT_BYTES);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IN_W  = IN_BYTES * 8;
    localparam int OUT_W = OUT_BYTES * 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    if (OUT_BYTES < 1) begin : g_bad_out_bytes
        $error("dvr_serializer: OUT_BYTES must be at least 1");
    end else if ((IN_BYTES % OUT_BYTES) != 0) begin : g_bad_ratio
        $error("dvr_serializer: IN_BYTES must be a multiple of OUT_BYTES");
    end

    dvr_ser_state_t   r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt,   w_next_cnt;
    logic [IN_W-1:0]  r_shift, w_next_shift;
    logic             w_is_last;
    logic             w_in_rdy;
    logic             w_accept;
    logic             w_send;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_shift <= w_next_shift;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_shift = r_shift;

        w_is_last = (r_state == SEND) && (r_cnt == LAST_IDX);
        // Ready is forwarded combinationally from the output side so a new word
        // can be taken on the same edge the last chunk leaves.
        w_in_rdy  = rst_n && ((r_state == IDLE) || (w_is_last && data_out.rdy));
        w_accept  = data_in.valid && w_in_rdy;
        w_send    = (r_state == SEND) && data_out.rdy;

        data_in.rdy    = w_in_rdy;
        data_out.valid = (r_state == SEND);
        data_out.data  = r_shift[IN_W-1 -: OUT_W];
        last_chunk     = w_is_last;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_shift = data_in.data;
                    w_next_cnt   = '0;
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (w_send) begin
                    if (!w_is_last) begin
                        w_next_shift = r_shift << OUT_W;
                        w_next_cnt   = r_cnt + 1'b1;
                    end else if (w_accept) begin
                        w_next_shift = data_in.data;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

`default_nettype wire
